// File: rtl/parking_pkg.sv
// parking_pkg: capacity schedule constants and capacity lookup helpers
package parking_pkg;
  localparam logic [8:0] UNI_DAY   = 9'd500;
  localparam logic [8:0] F_DAY     = 9'd200;
  localparam logic [8:0] UNI_13    = 9'd450;
  localparam logic [8:0] F_13      = 9'd250;
  localparam logic [8:0] UNI_14    = 9'd400;
  localparam logic [8:0] F_14      = 9'd300;
  localparam logic [8:0] UNI_15    = 9'd350;
  localparam logic [8:0] F_15      = 9'd350;
  localparam logic [8:0] UNI_NIGHT = 9'd200;
  localparam logic [8:0] F_NIGHT   = 9'd500;
  localparam logic [9:0] TOTAL_CAP = 10'd700;
  localparam logic [4:0] H_DAY     = 5'd8;
  localparam logic [4:0] H_13      = 5'd13;
  localparam logic [4:0] H_14      = 5'd14;
  localparam logic [4:0] H_15      = 5'd15;
  localparam logic [4:0] H_NIGHT   = 5'd16;

  function automatic logic [8:0] uni_capacity(input logic [4:0] hour);
    return (hour < H_DAY || hour >= H_NIGHT) ? UNI_NIGHT :
           (hour < H_13) ? UNI_DAY :
           (hour == H_13) ? UNI_13 :
           (hour == H_14) ? UNI_14 : UNI_15;
  endfunction

  // The two classes always share 700 spaces, so free capacity is the complement.
  function automatic logic [8:0] free_capacity(input logic [4:0] hour);
    logic [9:0] t;
    t = TOTAL_CAP - {1'b0, uni_capacity(hour)};
    return t[8:0];
  endfunction
endpackage

// File: rtl/parking_hour_clock.sv
// parking_hour_clock: cycle prescaler and hour-of-day counter
module parking_hour_clock #(
  parameter int CYCLES_PER_HOUR = 100,
  parameter int RESET_HOUR      = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] o_hour,
  output logic       o_hour_tick
);
  localparam int CW = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;

  logic [CW-1:0] r_count;
  logic [4:0]    r_hour;

  assign o_hour_tick = (r_count == CW'(CYCLES_PER_HOUR - 1));
  assign o_hour      = r_hour;

  // Count cycles within the hour; advance the hour on wrap, 23 rolls to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_hour  <= 5'(RESET_HOUR);
    end else if (o_hour_tick) begin
      r_count <= '0;
      r_hour  <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/parking_controller.sv
// parking_controller: two-class car park occupancy and scheduled capacity control
module parking_controller
  import parking_pkg::*;
#(
  parameter int CYCLES_PER_HOUR = 100,
  parameter int RESET_HOUR      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_entered,
  input  logic       is_uni_car_entered,
  input  logic       car_exited,
  input  logic       is_uni_car_exited,
  output logic [8:0] uni_parked_car,
  output logic [8:0] f_parked_car,
  output logic [8:0] uni_vacated_space,
  output logic [8:0] f_vacated_space,
  output logic       is_uni_vacated_space,
  output logic       is_vacated_space
);
  logic       r_ent, r_ent_d, r_ent_uni, r_ex, r_ex_d, r_ex_uni;
  logic [8:0] r_uni, r_f;
  logic [4:0] w_hour;
  logic       w_ent, w_ex;
  logic [8:0] w_uni_cap, w_f_cap, w_uni_post_ex, w_f_post_ex, w_uni_next, w_f_next;

  parking_hour_clock #(
    .CYCLES_PER_HOUR(CYCLES_PER_HOUR),
    .RESET_HOUR     (RESET_HOUR)
  ) u_hour_clock (
    .clk        (clk),
    .rst        (rst),
    .o_hour     (w_hour),
    .o_hour_tick()
  );

  assign w_ent          = r_ent & ~r_ent_d;
  assign w_ex           = r_ex & ~r_ex_d;
  assign uni_parked_car = r_uni;
  assign f_parked_car   = r_f;

  // Register sensors and class bits; the delayed copy turns levels into edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_ent, r_ent_d, r_ent_uni, r_ex, r_ex_d, r_ex_uni} <= '0;
    end else begin
      {r_ent, r_ent_d, r_ent_uni} <= {car_entered, r_ent, is_uni_car_entered};
      {r_ex, r_ex_d, r_ex_uni}    <= {car_exited, r_ex, is_uni_car_exited};
    end
  end

  // Exit is applied first so a same-cycle entry sees the freed space; vacancy never goes negative.
  always_comb begin
    w_uni_cap            = uni_capacity(w_hour);
    w_f_cap              = free_capacity(w_hour);
    w_uni_post_ex        = (w_ex && r_ex_uni && r_uni != '0) ? r_uni - 9'd1 : r_uni;
    w_f_post_ex          = (w_ex && !r_ex_uni && r_f != '0) ? r_f - 9'd1 : r_f;
    w_uni_next           = (w_ent && r_ent_uni && w_uni_cap > w_uni_post_ex) ? w_uni_post_ex + 9'd1 : w_uni_post_ex;
    w_f_next             = (w_ent && !r_ent_uni && w_f_cap > w_f_post_ex) ? w_f_post_ex + 9'd1 : w_f_post_ex;
    uni_vacated_space    = (w_uni_cap > r_uni) ? w_uni_cap - r_uni : '0;
    f_vacated_space      = (w_f_cap > r_f) ? w_f_cap - r_f : '0;
    is_uni_vacated_space = uni_vacated_space != '0;
    is_vacated_space     = f_vacated_space != '0;
  end

  // Parked counters per class.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_uni <= '0;
      r_f   <= '0;
    end else begin
      r_uni <= w_uni_next;
      r_f   <= w_f_next;
    end
  end
endmodule

// File: tb/tb_parking_controller.sv
// tb_parking_controller: randomized scoreboard bench against a schedule-level model
module tb_parking_controller;
  localparam int CPH = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic car_entered = 1'b0, is_uni_car_entered = 1'b0, car_exited = 1'b0, is_uni_car_exited = 1'b0;
  logic [8:0] uni_parked_car, f_parked_car, uni_vacated_space, f_vacated_space;
  logic is_uni_vacated_space, is_vacated_space;

  typedef struct {
    int    cyc;
    string name;
    int    up, fp, uv, fv;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0;
  int n;
  int m_uni = 0, m_f = 0;

  always #5 clk = ~clk;

  parking_controller #(.CYCLES_PER_HOUR(CPH), .RESET_HOUR(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .uni_parked_car      (uni_parked_car),
    .f_parked_car        (f_parked_car),
    .uni_vacated_space   (uni_vacated_space),
    .f_vacated_space     (f_vacated_space),
    .is_uni_vacated_space(is_uni_vacated_space),
    .is_vacated_space    (is_vacated_space)
  );

  // Rising edges since reset release; expectations are keyed by this count.
  always @(posedge clk or negedge rst) if (!rst) n <= 0; else n <= n + 1;

  function automatic int cap_uni(int h);
    if (h >= 8 && h <= 12) return 500;
    if (h == 13) return 450;
    if (h == 14) return 400;
    if (h == 15) return 350;
    return 200;
  endfunction

  function automatic int cap_f(int h);
    if (h >= 8 && h <= 12) return 200;
    if (h == 13) return 250;
    if (h == 14) return 300;
    if (h == 15) return 350;
    return 500;
  endfunction

  function automatic int hour_at(int c);
    return (8 + c / CPH) % 24;
  endfunction

  function automatic int vac(int cap, int p);
    return cap > p ? cap - p : 0;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic push_lit(string nm, int c, int up, int fp, int uv, int fv);
    q.push_back('{c, nm, up, fp, uv, fv});
  endtask

  task automatic push_model(string nm, int c);
    push_lit(nm, c, m_uni, m_f, vac(cap_uni(hour_at(c)), m_uni), vac(cap_f(hour_at(c)), m_f));
  endtask

  // Monitor: compare every expectation whose cycle has been reached.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= n) begin
      e = q.pop_front();
      if (e.cyc != n) check({e.name, "_late"}, n, e.cyc);
      check({e.name, "_uni_parked"}, int'(uni_parked_car), e.up);
      check({e.name, "_f_parked"}, int'(f_parked_car), e.fp);
      check({e.name, "_uni_vac"}, int'(uni_vacated_space), e.uv);
      check({e.name, "_f_vac"}, int'(f_vacated_space), e.fv);
      check({e.name, "_uni_flag"}, int'(is_uni_vacated_space), int'(e.uv != 0));
      check({e.name, "_f_flag"}, int'(is_vacated_space), int'(e.fv != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
  endtask

  task automatic check_reset_values(string nm);
    check({nm, "_uni_parked"}, int'(uni_parked_car), 0);
    check({nm, "_f_parked"}, int'(f_parked_car), 0);
    check({nm, "_uni_vac"}, int'(uni_vacated_space), 500);
    check({nm, "_f_vac"}, int'(f_vacated_space), 200);
    check({nm, "_flags"}, int'({is_uni_vacated_space, is_vacated_space}), 3);
  endtask

  task automatic do_reset();
    drain();
    rst = 1'b0;
    {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited} = '0;
    m_uni = 0;
    m_f = 0;
    tick();
    check_reset_values("reset_held");
    tick();
    rst = 1'b1;
    push_lit("reset_released", 0, 0, 0, 500, 200);
  endtask

  // One sensor event: high for a cycle, low for a cycle; model updates at the counting edge.
  task automatic pulse(bit ent, bit eu, bit ex, bit xu);
    int k = n;
    int h = hour_at(k + 1);
    if (ex) begin
      if (xu) begin
        if (m_uni > 0) m_uni--;
      end else if (m_f > 0) m_f--;
    end
    if (ent) begin
      if (eu) begin
        if (vac(cap_uni(h), m_uni) > 0) m_uni++;
      end else if (vac(cap_f(h), m_f) > 0) m_f++;
    end
    push_model("event", k + 2);
    {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited} = {ent, eu, ex, xu};
    tick();
    car_entered = 1'b0;
    car_exited = 1'b0;
    is_uni_car_entered = 1'($urandom);
    is_uni_car_exited = 1'($urandom);
    tick();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    do_reset();
    push_lit("idle_h13", 5 * CPH, 0, 0, 450, 250);
    push_lit("idle_h16", 8 * CPH, 0, 0, 200, 500);
    push_lit("idle_h0", 16 * CPH, 0, 0, 200, 500);
    push_lit("idle_h8", 24 * CPH, 0, 0, 500, 200);
    repeat (24 * CPH + 1) tick();

    do_reset();
    repeat (202) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    push_lit("free_full", n, 0, 200, 500, 0);
    repeat (520) pulse(1'b1, 1'b1, 1'b0, 1'b0);
    push_lit("uni_full", n, 500, 200, 0, 0);
    repeat (100) pulse(1'b0, 1'b0, 1'b1, 1'b1);
    push_lit("uni_exit100", n, 400, 200, 100, 0);
    repeat (100) pulse(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (50) pulse(1'b1, 1'b1, 1'b1, 1'b1);
    push_lit("uni_same_cycle", n, 500, 200, 0, 0);
    while (n < 8 * CPH) tick();
    push_lit("h16_no_evict", n, 500, 200, 0, 300);
    repeat (300) pulse(1'b0, 1'b0, 1'b1, 1'b1);
    push_lit("h16_exit300", n, 200, 200, 0, 300);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    push_lit("h16_exit301", n, 199, 200, 1, 300);

    do_reset();
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    push_lit("exit_empty", n, 0, 0, 500, 200);

    repeat (5) pulse(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    push_lit("pre_mid_reset", n, 5, 3, 495, 197);
    drain();
    car_entered = 1'b1;
    is_uni_car_entered = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1 check_reset_values("mid_reset");
    car_entered = 1'b0;
    m_uni = 0;
    m_f = 0;
    tick();
    rst = 1'b1;
    push_lit("after_mid_reset", 4, 0, 0, 500, 200);
    repeat (6) tick();

    do_reset();
    repeat (4000) begin
      pulse(1'($urandom_range(0, 99) < 65), 1'($urandom), 1'($urandom_range(0, 99) < 40), 1'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end

    drain();
    if (q.size() != 0) check("scoreboard_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
